// File: rtl/crossbar_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : crossbar_alloc
//  Description : Allocation controller for an N x N combinational crossbar.
//                Each output owns a round-robin arbiter that locks onto one
//                input until that input sends its last beat, and drives the
//                one-hot select column for that output.
//  Options     : CROSSBAR_ALLOC_TIMEOUT_EN - when defined, a lock whose owner
//                stalls for TIMEOUT consecutive cycles is released as if the
//                owner had sent its last beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module crossbar_alloc #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [N-1:0]           req,
    input  logic [N*$clog2(N)-1:0] dest,
    input  logic [N-1:0]           last,
    output logic [N-1:0]           grant,
    output logic [N*N-1:0]         sel,
    output logic [N-1:0]           busy
);

    localparam int DW = $clog2(N);
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // An input is granted when any output column selects it; every column is
    // decoded from registered state, so there is no path from req to grant.
    always_comb begin
        grant = '0;
        for (int o = 0; o < N; o++) begin
            grant = grant | sel[o*N +: N];
        end
    end

    genvar go;
    generate
        for (go = 0; go < N; go++) begin : g_out
            state_t          state;
            state_t          state_nxt;
            logic [DW-1:0]   own;
            logic [DW-1:0]   own_nxt;
            logic [DW-1:0]   ptr;
            logic [DW-1:0]   ptr_nxt;
            logic [N-1:0]    cand;
            logic            beat;
            logic            timed_out;
            logic            release_lock;
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
            logic [CW-1:0]   cnt;
            logic [CW-1:0]   cnt_nxt;
`endif

            // Inputs asking for this output; an input that already owns some
            // output is left out so it can never hold two grants at once.
            always_comb begin
                cand = '0;
                for (int i = 0; i < N; i++) begin
                    cand[i] = req[i] && (dest[i*DW +: DW] == DW'(go)) && !grant[i];
                end
            end

            assign beat = (state == ST_LOCKED) && req[own];

`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
            // A stall reaching TIMEOUT cycles on this edge forces a release.
            assign timed_out = (state == ST_LOCKED) && !req[own] &&
                               (cnt == CW'(TIMEOUT - 1));
`else
            assign timed_out = 1'b0;
`endif

            assign release_lock = (beat && last[own]) || timed_out;

            // Next-state logic: round-robin pick when idle, release on last beat.
            always_comb begin
                state_nxt = state;
                own_nxt   = own;
                ptr_nxt   = ptr;
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
                cnt_nxt   = cnt;
`endif
                case (state)
                    ST_IDLE: begin
                        // Scan ptr+1, ptr+2, ... with wrap; the first hit wins.
                        for (int k = N; k >= 1; k--) begin
                            for (int i = 0; i < N; i++) begin
                                if (cand[i] &&
                                    (i == ((int'(ptr) + k >= N) ? int'(ptr) + k - N
                                                                 : int'(ptr) + k))) begin
                                    own_nxt   = DW'(i);
                                    state_nxt = ST_LOCKED;
                                end
                            end
                        end
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
                        cnt_nxt = '0;
`endif
                    end
                    ST_LOCKED: begin
                        if (release_lock) begin
                            state_nxt = ST_IDLE;
                            ptr_nxt   = own;
                        end
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
                        if (release_lock || beat) begin
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
`endif
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                    end
                endcase
            end

            // State, owner and priority pointer registers.
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    state <= ST_IDLE;
                    own   <= '0;
                    ptr   <= DW'(N - 1);
                end else begin
                    state <= state_nxt;
                    own   <= own_nxt;
                    ptr   <= ptr_nxt;
                end
            end

`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
            // Stall counter for the current lock.
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end
`endif

            assign sel[go*N +: N] = (state == ST_LOCKED) ? (N'(1) << own) : '0;
            assign busy[go]       = (state == ST_LOCKED);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_crossbar_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crossbar_alloc
//  Description : Directed self-checking bench for crossbar_alloc with a
//                cycle-level allocation model and literal spot checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crossbar_alloc;

    localparam int N       = 4;
    localparam int DW      = 2;
    localparam int TIMEOUT = 16;

    logic            clk    = 1'b0;
    logic            nreset = 1'b1;
    logic [N-1:0]    req    = '0;
    logic [N-1:0]    last   = '0;
    logic [N*DW-1:0] dest   = '0;
    logic [N-1:0]    grant;
    logic [N*N-1:0]  sel;
    logic [N-1:0]    busy;

    int checks   = 0;
    int failures = 0;

    // Model state: which outputs are locked, to whom, and their rr pointer.
    bit m_lock [N];
    int m_own  [N];
    int m_ptr  [N];
    int m_cnt  [N];

    always #5 clk = ~clk;

    crossbar_alloc #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .req    (req),
        .dest   (dest),
        .last   (last),
        .grant  (grant),
        .sel    (sel),
        .busy   (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    function automatic int dest_of(input int i);
        logic [DW-1:0] d;
        d = dest[i*DW +: DW];
        return int'(d);
    endfunction

    function automatic bit input_held(input int i);
        bit h;
        h = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (m_lock[o] && m_own[o] == i) h = 1'b1;
        end
        return h;
    endfunction

    // Round-robin choice for an idle output: first requester after the pointer.
    function automatic int pick_winner(input int o);
        int w;
        w = -1;
        for (int s = 1; s <= N; s++) begin
            int c;
            c = (m_ptr[o] + s) % N;
            if (w < 0 && req[c] && dest_of(c) == o && !input_held(c)) w = c;
        end
        return w;
    endfunction

    function automatic logic [N*N-1:0] exp_sel();
        logic [N*N-1:0] s;
        s = '0;
        for (int o = 0; o < N; o++) begin
            if (m_lock[o]) s[o*N + m_own[o]] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        for (int o = 0; o < N; o++) begin
            if (m_lock[o]) g[m_own[o]] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [N-1:0] exp_busy();
        logic [N-1:0] b;
        b = '0;
        for (int o = 0; o < N; o++) begin
            b[o] = m_lock[o];
        end
        return b;
    endfunction

    // Allocation model, advanced on each rising edge.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int o = 0; o < N; o++) begin
                m_lock[o] <= 1'b0;
                m_own[o]  <= 0;
                m_ptr[o]  <= N - 1;
                m_cnt[o]  <= 0;
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                if (m_lock[o]) begin
                    if (req[m_own[o]] && last[m_own[o]]) begin
                        m_lock[o] <= 1'b0;
                        m_ptr[o]  <= m_own[o];
                        m_cnt[o]  <= 0;
                    end else if (req[m_own[o]]) begin
                        m_cnt[o] <= 0;
                    end else begin
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
                        if (m_cnt[o] + 1 >= TIMEOUT) begin
                            m_lock[o] <= 1'b0;
                            m_ptr[o]  <= m_own[o];
                            m_cnt[o]  <= 0;
                        end else begin
                            m_cnt[o] <= m_cnt[o] + 1;
                        end
`endif
                    end
                end else if (pick_winner(o) >= 0) begin
                    m_lock[o] <= 1'b1;
                    m_own[o]  <= pick_winner(o);
                    m_cnt[o]  <= 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if ($time > 2) begin
            chk("model_grant", 32'(grant), 32'(exp_grant()));
            chk("model_sel",   32'(sel),   32'(exp_sel()));
            chk("model_busy",  32'(busy),  32'(exp_busy()));
        end
    end

    task automatic drive(input int i, input bit r, input int d, input bit l);
        logic [DW-1:0] dv;
        dv = DW'(d);
        req[i]            = r;
        dest[i*DW +: DW]  = dv;
        last[i]           = l;
    endtask

    task automatic clear_in();
        req  = '0;
        last = '0;
        dest = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        #2 nreset = 1'b0;
        @(negedge clk);
        #2 nreset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] eg;
        #1 nreset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel",   32'(sel),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);

        // Single-beat packet from input 0 to output 2 right after reset release.
        #2 nreset = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 2, 1'b1);
        @(negedge clk);
        chk("t1_sel",   32'(sel),   32'h0100);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy",  32'(busy),  32'h4);
        @(negedge clk);
        chk("t1_sel_off",   32'(sel),   32'h0);
        chk("t1_grant_off", 32'(grant), 32'h0);
        chk("t1_busy_off",  32'(busy),  32'h0);
        clear_in();

        // All inputs contend for output 1 with single-beat packets.
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1, 1'b1);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            eg = (n % 2 == 1) ? (4'b0001 << (((n - 1) / 2) % 4)) : 4'b0000;
            chk("t2_rr_grant", 32'(grant),    32'(eg));
            chk("t2_rr_col1",  32'(sel[7:4]), 32'(eg));
        end
        clear_in();

        // Four-beat packet from input 1 to output 3 with a stall; input 2 waits.
        do_reset();
        drive(1, 1'b1, 3, 1'b0);
        drive(2, 1'b1, 3, 1'b1);
        @(negedge clk);
        chk("t3_col3", 32'(sel[15:12]), 32'h2);
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        chk("t3_stall_col3",  32'(sel[15:12]), 32'h2);
        chk("t3_stall_busy",  32'(busy[3]),    32'h1);
        chk("t3_stall_grant", 32'(grant),      32'h2);
        req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        last[1] = 1'b1;
        @(negedge clk);
        chk("t3_bubble_grant", 32'(grant), 32'h0);
        chk("t3_bubble_busy",  32'(busy),  32'h0);
        drive(1, 1'b0, 3, 1'b0);
        @(negedge clk);
        chk("t3_next_grant", 32'(grant),       32'h4);
        chk("t3_next_col3",  32'(sel[15:12]), 32'h4);
        @(negedge clk);
        clear_in();

        // Fully parallel allocation: input i to output 3-i.
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, N - 1 - i, 1'b1);
        @(negedge clk);
        chk("t4_sel",   32'(sel),   32'h1248);
        chk("t4_grant", 32'(grant), 32'hF);
        chk("t4_busy",  32'(busy),  32'hF);
        @(negedge clk);
        chk("t4_release", 32'(sel), 32'h0);
        clear_in();

        // Reset mid-packet; afterwards input 0 must win despite a moved pointer.
        do_reset();
        drive(0, 1'b1, 2, 1'b1);
        @(negedge clk);
        chk("t5_first", 32'(grant), 32'h1);
        @(negedge clk);
        clear_in();
        drive(3, 1'b1, 2, 1'b0);
        @(negedge clk);
        chk("t5_locked_grant", 32'(grant), 32'h8);
        chk("t5_locked_busy",  32'(busy),  32'h4);
        #2 nreset = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 32'h0);
        chk("t5_async_sel",   32'(sel),   32'h0);
        chk("t5_async_busy",  32'(busy),  32'h0);
        @(negedge clk);
        clear_in();
        drive(0, 1'b1, 2, 1'b1);
        drive(1, 1'b1, 2, 1'b1);
        #2 nreset = 1'b1;
        @(negedge clk);
        chk("t5_winner", 32'(grant), 32'h1);
        @(negedge clk);
        clear_in();

`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
        // Owner stalls forever after one beat; the lock times out.
        do_reset();
        drive(0, 1'b1, 0, 1'b0);
        drive(1, 1'b1, 0, 1'b1);
        @(negedge clk);
        chk("t6_grant", 32'(grant), 32'h1);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6_still_busy", 32'(busy[0]), 32'h1);
        @(negedge clk);
        chk("t6_timeout_busy",  32'(busy[0]), 32'h0);
        chk("t6_timeout_grant", 32'(grant),   32'h0);
        @(negedge clk);
        chk("t6_waiter", 32'(grant), 32'h2);
        @(negedge clk);
        clear_in();
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
